cache_refill_arbiter: RTL and testbench

// Shares one AXI4 read channel (AR/R) between the ICache and DCache line-refill ports. Grants one miss at a time and issues
// an 8-beat INCR burst for the line-aligned address. Assembles the 8 returned words into a 256-bit line and returns it to the

---
 rtl/cache_refill_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_refill_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_arbiter.sv
// Round-robin refill arbiter that lets the ICache and DCache share one AXI4 read channel.
// Each granted miss becomes one INCR burst, and the assembled line goes back to the granted cache as a single-cycle pulse.
module cache_refill_arbiter #(
   parameter int         LINE_WORDS = 8,
   parameter logic [3:0] ICACHE_ID  = 4'd0,
   parameter logic [3:0] DCACHE_ID  = 4'd1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     icache_ren_i,
   input  logic [31:0]              icache_araddr_i,
   output logic                     icache_rvalid_o,
   output logic [32*LINE_WORDS-1:0] icache_rdata_o,
   input  logic                     dcache_ren_i,
   input  logic [31:0]              dcache_araddr_i,
   output logic                     dcache_rvalid_o,
   output logic [32*LINE_WORDS-1:0] dcache_rdata_o,
   output logic [3:0]               arid,
   output logic [31:0]              araddr,
   output logic [7:0]               arlen,
   output logic [2:0]               arsize,
   output logic [1:0]               arburst,
   output logic                     arvalid,
   input  logic                     arready,
   input  logic [3:0]               rid,
   input  logic [31:0]              rdata,
   input  logic [1:0]               rresp,
   input  logic                     rlast,
   input  logic                     rvalid,
   output logic                     rready
);

   localparam int          CNT_W       = $clog2(LINE_WORDS);
   localparam logic [31:0] OFFSET_MASK = 32'(LINE_WORDS * 4 - 1);

   typedef enum logic [1:0] {IDLE, AR, RD, DONE} state_t;

   state_t            state_reg, state_next;
   logic              owner_reg, owner_next;          // 1 = DCache
   logic              last_grant_reg, last_grant_next;
   logic [31:0]       addr_reg, addr_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [31:0]       line_reg [LINE_WORDS];
   logic              beat;
   logic              grant_d;

   // Responses are accepted regardless of ID or error status.
   logic unused_inputs;
   assign unused_inputs = ^{rid, rresp};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b0;
         addr_reg       <= '0;
         cnt_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
         addr_reg       <= addr_next;
         cnt_reg        <= cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      addr_next       = addr_reg;
      cnt_next        = cnt_reg;
      grant_d         = 1'b0;
      beat            = 1'b0;
      arvalid         = 1'b0;
      rready          = 1'b0;
      icache_rvalid_o = 1'b0;
      dcache_rvalid_o = 1'b0;
      case (state_reg)
         IDLE: begin
            if (icache_ren_i || dcache_ren_i) begin
               // On a tie, the cache that was not granted last time wins.
               grant_d         = dcache_ren_i && (!icache_ren_i || !last_grant_reg);
               owner_next      = grant_d;
               last_grant_next = grant_d;
               addr_next       = (grant_d ? dcache_araddr_i : icache_araddr_i) & ~OFFSET_MASK;
               state_next      = AR;
            end
         end
         AR: begin
            arvalid = 1'b1;
            if (arready) state_next = RD;
         end
         RD: begin
            rready = 1'b1;
            if (rvalid) begin
               beat = 1'b1;
               if (rlast) begin
                  cnt_next   = '0;
                  state_next = DONE;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         DONE: begin
            // If the owner has already withdrawn its request (flush), the pulse is suppressed.
            icache_rvalid_o = !owner_reg && icache_ren_i;
            dcache_rvalid_o = owner_reg && dcache_ren_i;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign arid    = owner_reg ? DCACHE_ID : ICACHE_ID;
   assign araddr  = addr_reg;
   assign arlen   = 8'(LINE_WORDS - 1);
   assign arsize  = 3'b010;
   assign arburst = 2'b01;

   generate
      for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line
         always_ff @(posedge clk) begin
            if (!rst)
               line_reg[gi] <= '0;
            else if (beat && cnt_reg == CNT_W'(gi))
               line_reg[gi] <= rdata;
         end
         assign icache_rdata_o[32*gi +: 32] = line_reg[gi];
         assign dcache_rdata_o[32*gi +: 32] = line_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed testbench for cache_refill_arbiter.
// A scripted AXI slave supplies the bursts, and an expected line model is kept in the bench and checked at each comparison point.
module tb_cache_refill_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         icache_ren_i, dcache_ren_i;
   logic [31:0]  icache_araddr_i, dcache_araddr_i;
   logic         icache_rvalid_o, dcache_rvalid_o;
   logic [255:0] icache_rdata_o, dcache_rdata_o;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid, arready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast, rvalid, rready;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_line [8];

   always #5 clk = ~clk;

   cache_refill_arbiter #(.LINE_WORDS(8), .ICACHE_ID(4'd0), .DCACHE_ID(4'd1)) dut (
      .clk(clk), .rst(rst),
      .icache_ren_i(icache_ren_i), .icache_araddr_i(icache_araddr_i),
      .icache_rvalid_o(icache_rvalid_o), .icache_rdata_o(icache_rdata_o),
      .dcache_ren_i(dcache_ren_i), .dcache_araddr_i(dcache_araddr_i),
      .dcache_rvalid_o(dcache_rvalid_o), .dcache_rdata_o(dcache_rdata_o),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] packed_line();
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = exp_line[i];
      return r;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 8; i++) exp_line[i] = 32'h0;
   endtask

   // Called in IDLE; expects AR one cycle later, then stalls arready for 'stall' cycles.
   task automatic do_ar(input logic [3:0] exp_id, input logic [31:0] exp_addr, input int stall);
      int waited;
      waited = 0;
      while (!arvalid && waited < 20) begin
         step();
         waited++;
      end
      chk("ar_latency", 256'(waited), 256'(1));
      chk("arid", 256'(arid), 256'(exp_id));
      chk("araddr", 256'(araddr), 256'(exp_addr));
      chk("arlen", 256'(arlen), 256'(7));
      chk("arsize", 256'(arsize), 256'(2));
      chk("arburst", 256'(arburst), 256'(1));
      chk("rready_low_in_ar", 256'(rready), 256'(0));
      for (int s = 0; s < stall; s++) begin
         arready = 1'b0;
         step();
         chk("ar_hold_valid", 256'(arvalid), 256'(1));
         chk("ar_hold_addr", 256'(araddr), 256'(exp_addr));
         chk("ar_hold_id", 256'(arid), 256'(exp_id));
         chk("ar_hold_len", 256'(arlen), 256'(7));
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("ar_drop", 256'(arvalid), 256'(0));
      chk("rready_on", 256'(rready), 256'(1));
   endtask

   // Sends nbeats beats (last with rlast). Gapped mode inserts i%4 idle cycles before beat i.
   task automatic do_beats(input logic [31:0] base, input int nbeats, input int gapped,
                           input int withdraw_at, input logic exp_i, input logic exp_d);
      for (int i = 0; i < nbeats; i++) begin
         for (int g = 0; g < (gapped != 0 ? i % 4 : 0); g++) begin
            rvalid = 1'b0;
            step();
         end
         if (i == withdraw_at) icache_ren_i = 1'b0;
         chk("rready_beat", 256'(rready), 256'(1));
         rvalid = 1'b1;
         rdata  = base + 32'(i);
         rlast  = (i == nbeats - 1);
         rid    = 4'hF;
         rresp  = 2'b10;
         step();
         exp_line[i] = base + 32'(i);
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      chk("icache_rvalid_done", 256'(icache_rvalid_o), 256'(exp_i));
      chk("dcache_rvalid_done", 256'(dcache_rvalid_o), 256'(exp_d));
      chk("rready_off_done", 256'(rready), 256'(0));
      if (exp_i) chk("icache_line", icache_rdata_o, packed_line());
      if (exp_d) chk("dcache_line", dcache_rdata_o, packed_line());
      $display("refill base=%08h beats=%0d araddr=%08h arid=%0d ipulse=%0b dpulse=%0b",
               base, nbeats, araddr, arid, icache_rvalid_o, dcache_rvalid_o);
   endtask

   initial begin
      logic dk;
      rst = 1'b0;
      icache_ren_i = 1'b0; dcache_ren_i = 1'b0;
      icache_araddr_i = '0; dcache_araddr_i = '0;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
      clear_model();
      repeat (3) step();

      // Reset state
      chk("rst_arvalid", 256'(arvalid), 256'(0));
      chk("rst_rready", 256'(rready), 256'(0));
      chk("rst_ipulse", 256'(icache_rvalid_o), 256'(0));
      chk("rst_dpulse", 256'(dcache_rvalid_o), 256'(0));
      chk("rst_line", icache_rdata_o, 256'(0));
      rst = 1'b1;
      step();

      // ICache-only refill, offset address
      icache_araddr_i = 32'h1FC0_0014;
      icache_ren_i    = 1'b1;
      do_ar(4'd0, 32'h1FC0_0000, 0);
      do_beats(32'h0000_00A0, 8, 0, -1, 1'b1, 1'b0);
      icache_ren_i = 1'b0;
      step();
      chk("t1_pulse_one_cycle", 256'(icache_rvalid_o), 256'(0));
      chk("t1_idle_arvalid", 256'(arvalid), 256'(0));

      // Fresh reset, then both requests held: grant order D,I,D,I
      rst = 1'b0;
      step();
      rst = 1'b1;
      clear_model();
      step();
      icache_araddr_i = 32'h1000_0008;
      dcache_araddr_i = 32'h8000_0044;
      icache_ren_i = 1'b1;
      dcache_ren_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         dk = (k % 2 == 0);
         do_ar(dk ? 4'd1 : 4'd0, dk ? 32'h8000_0040 : 32'h1000_0000, 0);
         do_beats(32'hB000_0000 + 32'(k * 256), 8, 0, -1, !dk, dk);
         if (k == 3) begin
            icache_ren_i = 1'b0;
            dcache_ren_i = 1'b0;
         end
         step();
         chk("rr_ipulse_idle", 256'(icache_rvalid_o), 256'(0));
         chk("rr_dpulse_idle", 256'(dcache_rvalid_o), 256'(0));
      end

      // arready stalled for 5 cycles
      icache_araddr_i = 32'h0000_1234;
      icache_ren_i    = 1'b1;
      do_ar(4'd0, 32'h0000_1220, 5);
      do_beats(32'h4000_0000, 8, 0, -1, 1'b1, 1'b0);
      icache_ren_i = 1'b0;
      step();

      // rvalid gaps of 0..3 cycles
      icache_araddr_i = 32'h2000_003C;
      icache_ren_i    = 1'b1;
      do_ar(4'd0, 32'h2000_0020, 0);
      do_beats(32'h5000_0000, 8, 1, -1, 1'b1, 1'b0);
      icache_ren_i = 1'b0;
      step();

      // Early rlast after 3 beats: words 3..7 keep the previous line
      icache_araddr_i = 32'h3000_0000;
      icache_ren_i    = 1'b1;
      do_ar(4'd0, 32'h3000_0000, 0);
      do_beats(32'h6000_0000, 3, 0, -1, 1'b1, 1'b0);
      icache_ren_i = 1'b0;
      step();

      // Flush: ICache withdraws at beat 4, burst drained, no pulse
      icache_araddr_i = 32'h4000_0050;
      icache_ren_i    = 1'b1;
      do_ar(4'd0, 32'h4000_0040, 0);
      do_beats(32'h7000_0000, 8, 1, 4, 1'b0, 1'b0);
      step();
      chk("flush_idle_arvalid", 256'(arvalid), 256'(0));
      chk("flush_idle_rready", 256'(rready), 256'(0));
      step();
      chk("flush_stay_idle", 256'(arvalid), 256'(0));
      chk("flush_no_pulse", 256'(icache_rvalid_o), 256'(0));

      // Reset during beat 3
      icache_araddr_i = 32'h5000_0000;
      icache_ren_i    = 1'b1;
      do_ar(4'd0, 32'h5000_0000, 0);
      for (int i = 0; i < 3; i++) begin
         rvalid = 1'b1;
         rdata  = 32'h8000_0000 + 32'(i);
         rlast  = 1'b0;
         step();
      end
      rdata = 32'h8000_0003;
      rst   = 1'b0;
      step();
      chk("mid_rst_arvalid", 256'(arvalid), 256'(0));
      chk("mid_rst_rready", 256'(rready), 256'(0));
      chk("mid_rst_ipulse", 256'(icache_rvalid_o), 256'(0));
      chk("mid_rst_line", icache_rdata_o, 256'(0));
      rvalid = 1'b0;
      icache_ren_i = 1'b0;
      rst = 1'b1;
      clear_model();
      step();
      icache_araddr_i = 32'h0000_2468;
      icache_ren_i    = 1'b1;
      do_ar(4'd0, 32'h0000_2460, 0);
      do_beats(32'h0000_00C0, 8, 0, -1, 1'b1, 1'b0);
      icache_ren_i = 1'b0;
      step();
      chk("post_rst_idle", 256'(arvalid), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
